gpu_warp_l1: RTL and testbench
==============================

# gpu_warp_l1

SIMT warp execution unit with a private L1 instruction store for the GPU core. Starting from a supplied program counter, it fetches 16-bit instructions, executes each one in lockstep across all lanes, and exports the current PC. It raises `exit` when the program executes EXIT. The GPU top level drives `pc` and monitors `exit`/`pc_out`.

## Interface
- `LANES`, 4: lanes per warp; lane ids run 0..LANES-1.
- `IMEM_DEPTH`, 256: instruction store depth in 16-bit words; power of two.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch pulse; accepted only in IDLE or HALT.
- `pc` in 16: launch PC, latched when `start` is accepted.
- `imem_we` in 1: instruction store write enable; ignored while `busy`.
- `imem_addr` in 16: write address; only the low log2(IMEM_DEPTH) bits are used.
- `imem_wdata` in 16: instruction word to write.
- `dbg_lane` in 2, `dbg_reg` in 3: register observation select.
- `dbg_data` out 16: combinational read of the selected lane register.
- `pc_out` out 16: PC of the next instruction to fetch.
- `busy` out 1: high in FETCH and EXEC.
- `exit` out 1: high in HALT.

## Operation
- Every lane has 8 registers of 16 bits, r0..r7. Reading r0 returns the lane id. Writes to r0 are discarded.
- Instruction fields: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm6=[5:0] (sign-extended), imm9=[8:0] (zero-extended), imm12=[11:0] (zero-extended).
- Opcodes. Arithmetic is per lane and wraps modulo 2^16.
  - 0 NOP: no effect.
  - 1 ADD: rd=rs+rt.
  - 2 SUB: rd=rs-rt.
  - 3 ADDI: rd=rs+imm6.
  - 4 LDI: rd=imm9.
  - 5 JMP: pc=imm12.
  - 6 BNZ: if lane 0's rs≠0, pc=pc+1+imm6; otherwise pc+1. The branch is warp-uniform and no divergence is tracked.
  - F EXIT: enter HALT.
  - Every other opcode executes as NOP.
- The default next PC is pc+1, wrapping from 0xFFFF to 0x0000.
- The instruction store address is pc modulo IMEM_DEPTH.
- States:
  - IDLE: entered on reset.
  - IDLE/HALT + `start` → FETCH, with pc_out←`pc`.
  - FETCH → EXEC: the store read is issued at address pc_out.
  - EXEC: the instruction is valid. Register writes and the pc_out update happen on the exiting edge. Next state is FETCH, or HALT for EXIT.
  - HALT: holds until `start`.
- EXIT leaves pc_out at the EXIT address + 1. Registers keep their values across HALT and relaunch.
- `start` while busy is ignored. `imem_we` while busy is ignored. In IDLE/HALT, a write and a `start` in the same cycle both take effect; the write lands before the first fetch.
- The instruction store contents are not cleared by reset.

## Timing
- Reset values: pc_out=0, busy=0, exit=0, state IDLE, all r1..r7=0.
- Reset asserted mid-program aborts the program immediately to IDLE.
- Every instruction takes 2 cycles. The store has 1-cycle synchronous read latency.
- The cycle after `start` is accepted shows busy=1.
- After EXEC of EXIT, `exit`=1 on the next cycle and busy=0.
- A program of N instructions ending in EXIT sets exit exactly 2N cycles after the start edge.
- `dbg_data` reflects register writes in the cycle after EXEC.

## Structure
- Package `gpu_warp_pkg` holds:
  - opcode localparams;
  - the state enum (IDLE, FETCH, EXEC, HALT);
  - field-extraction width constants.
- Sub-module `gpu_l1_icache`: IMEM_DEPTH×16 single-port store with a write port and a synchronous read port.
- The top level holds the FSM, decode, and a generate loop of lane register files and ALUs.

## Test plan
- Load [LDI r1,5; ADDI r2,r1,-1; ADD r3,r0,r2; EXIT] at 0, then start with pc=0:
  - exit rises 8 cycles after start;
  - lane k r3=4+k;
  - pc_out=4.
- Load JMP 0x010 at 0 and EXIT at 0x010: pc_out=0x011 at exit. The instruction at 1 never executes; check r1 unchanged.
- BNZ loop: LDI r1,3; ADDI r1,r1,-1; BNZ r1,-2; EXIT. Loop body runs 3 times; r1=0; exit after 2×(1+3+3+1)=16 cycles.
- Write r0 with LDI r0,7: lane k still reads k.
- Program wrap: start with pc=0xFFFF and EXIT at address 0xFF (IMEM_DEPTH 256): exit asserts and pc_out=0x0000.
- Drop rst_n mid-loop: busy=0, exit=0, pc_out=0 at once. `imem_we` and `start` while busy have no effect.

Source files
------------

// File: rtl/gpu_warp_pkg.sv
// Shared definitions for the SIMT warp unit: opcodes, FSM states, field widths.
package gpu_warp_pkg;

    localparam int WORD_W    = 16;
    localparam int OP_W      = 4;
    localparam int REG_SEL_W = 3;
    localparam int IMM6_W    = 6;
    localparam int IMM9_W    = 9;
    localparam int IMM12_W   = 12;
    localparam int NUM_REGS  = 8;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h3;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h4;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h5;
    localparam logic [OP_W-1:0] OP_BNZ  = 4'h6;
    localparam logic [OP_W-1:0] OP_EXIT = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Sign-extend the 6-bit immediate used by ADDI and BNZ.
    function automatic logic [WORD_W-1:0] sext6(input logic [IMM6_W-1:0] v);
        return {{(WORD_W-IMM6_W){v[IMM6_W-1]}}, v};
    endfunction

endpackage

// File: rtl/gpu_l1_icache.sv
// Private L1 instruction store: one shared address, write port plus 1-cycle synchronous read.
// Contents are deliberately not reset so a loaded program survives a reset.
module gpu_l1_icache #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Write when enabled and always register the word at the current address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/gpu_warp_l1.sv
// SIMT warp execution unit: fetch/exec FSM, decode, and per-lane register files and ALUs.
// Branches are decided by lane 0 alone; the warp never diverges.
module gpu_warp_l1
    import gpu_warp_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] pc,
    input  logic        imem_we,
    input  logic [15:0] imem_addr,
    input  logic [15:0] imem_wdata,
    input  logic [1:0]  dbg_lane,
    input  logic [2:0]  dbg_reg,
    output logic [15:0] dbg_data,
    output logic [15:0] pc_out,
    output logic        busy,
    output logic        exit
);

    localparam int AW = $clog2(IMEM_DEPTH);

    state_t              state;
    logic [WORD_W-1:0]   instr;
    logic [OP_W-1:0]     op;
    logic [REG_SEL_W-1:0] rd, rs, rt;
    logic [WORD_W-1:0]   imm6_x, imm9_x, imm12_x;
    logic [WORD_W-1:0]   next_pc;
    logic                reg_we;
    logic                cache_we;
    logic [AW-1:0]       cache_addr;
    logic [WORD_W-1:0]   lane_dbg [LANES];
    logic                unused_addr_bits;

    assign busy = (state == FETCH) || (state == EXEC);
    assign exit = (state == HALT);

    // While running the store is owned by the fetcher; otherwise by the loader.
    assign cache_we         = imem_we && !busy;
    assign cache_addr       = busy ? pc_out[AW-1:0] : imem_addr[AW-1:0];
    assign unused_addr_bits = ^imem_addr[15:AW];

    gpu_l1_icache #(
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_icache (
        .clk   (clk),
        .we    (cache_we),
        .addr  (cache_addr),
        .wdata (imem_wdata),
        .rdata (instr)
    );

    assign op      = instr[15:12];
    assign rd      = instr[11:9];
    assign rs      = instr[8:6];
    assign rt      = instr[5:3];
    assign imm6_x  = sext6(instr[5:0]);
    assign imm9_x  = {{(WORD_W-IMM9_W){1'b0}}, instr[8:0]};
    assign imm12_x = {{(WORD_W-IMM12_W){1'b0}}, instr[11:0]};

    // Register write strobe shared by all lanes; r0 is never written.
    assign reg_we = (state == EXEC) && (rd != 3'd0) &&
                    ((op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_LDI));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [WORD_W-1:0] LANE_ID = WORD_W'(l);

        logic [WORD_W-1:0] rf [NUM_REGS];
        logic [WORD_W-1:0] rs_val;
        logic [WORD_W-1:0] rt_val;
        logic [WORD_W-1:0] alu_res;

        assign rs_val      = (rs == 3'd0) ? LANE_ID : rf[rs];
        assign rt_val      = (rt == 3'd0) ? LANE_ID : rf[rt];
        assign lane_dbg[l] = (dbg_reg == 3'd0) ? LANE_ID : rf[dbg_reg];

        // Per-lane ALU result for the register-writing opcodes.
        always_comb begin
            alu_res = '0;
            case (op)
                OP_ADD:  alu_res = rs_val + rt_val;
                OP_SUB:  alu_res = rs_val - rt_val;
                OP_ADDI: alu_res = rs_val + imm6_x;
                OP_LDI:  alu_res = imm9_x;
                default: alu_res = '0;
            endcase
        end

        // Lane register file; cleared by reset, kept across HALT and relaunch.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    rf[i] <= '0;
                end
            end else if (reg_we) begin
                rf[rd] <= alu_res;
            end
        end
    end

    assign dbg_data = lane_dbg[dbg_lane];

    // Next PC: sequential by default, JMP absolute, BNZ relative when lane 0's rs is nonzero.
    always_comb begin
        next_pc = pc_out + 16'd1;
        case (op)
            OP_JMP: next_pc = imm12_x;
            OP_BNZ: begin
                if (g_lane[0].rs_val != '0) begin
                    next_pc = pc_out + 16'd1 + imm6_x;
                end
            end
            default: next_pc = pc_out + 16'd1;
        endcase
    end

    // Warp control FSM: launch, two-cycle fetch/execute per instruction, halt on EXIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc_out <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state  <= FETCH;
                        pc_out <= pc;
                    end
                end
                FETCH: state <= EXEC;
                EXEC: begin
                    pc_out <= next_pc;
                    state  <= (op == OP_EXIT) ? HALT : FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_warp_l1.sv
// Scoreboard bench for gpu_warp_l1: stimulus queues expectations per launch,
// a monitor drains them whenever exit rises.
module tb_gpu_warp_l1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pc = 16'h0;
    logic        imem_we = 1'b0;
    logic [15:0] imem_addr = 16'h0;
    logic [15:0] imem_wdata = 16'h0;
    logic [1:0]  dbg_lane;
    logic [2:0]  dbg_reg;
    logic [15:0] dbg_data;
    logic [15:0] pc_out;
    logic        busy;
    logic        exit;

    logic        mon_active = 1'b0;
    logic [1:0]  mon_lane = 2'd0;
    logic [2:0]  mon_reg = 3'd0;
    logic [1:0]  stim_lane = 2'd0;
    logic [2:0]  stim_reg = 3'd0;

    assign dbg_lane = mon_active ? mon_lane : stim_lane;
    assign dbg_reg  = mon_active ? mon_reg  : stim_reg;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int checks_done = 0;

    // kind: 0 exit cycle, 1 pc_out, 2 lane register, 3 busy
    typedef struct {
        int    kind;
        int    lane;
        int    rsel;
        int    expv;
        string name;
    } exp_t;

    exp_t sb[$];

    gpu_warp_l1 #(.LANES(4), .IMEM_DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pc         (pc),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dbg_lane   (dbg_lane),
        .dbg_reg    (dbg_reg),
        .dbg_data   (dbg_data),
        .pc_out     (pc_out),
        .busy       (busy),
        .exit       (exit)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to time exit against the start edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushItem(input int kind, input int lane, input int rsel, input int expv,
                            input string name);
        exp_t it;
        it.kind = kind;
        it.lane = lane;
        it.rsel = rsel;
        it.expv = expv;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic pushReg(input int lane, input int rsel, input int expv, input string tag);
        pushItem(2, lane, rsel, expv, $sformatf("%s_l%0d_r%0d", tag, lane, rsel));
    endtask

    // Drive one cycle of inputs from a negedge, hold across the posedge, then release pulses.
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] data,
                                 input logic st, input logic [15:0] launch_pc);
        @(negedge clk);
        imem_we    = we;
        imem_addr  = addr;
        imem_wdata = data;
        start      = st;
        pc         = launch_pc;
        @(posedge clk);
        #1;
        imem_we = 1'b0;
        start   = 1'b0;
    endtask

    task automatic loadWord(input logic [15:0] addr, input logic [15:0] data);
        applyStimulus(1'b1, addr, data, 1'b0, 16'h0);
    endtask

    // Start a program (optionally with a same-cycle store write) and queue its exit timing.
    task automatic launch(input logic we, input logic [15:0] addr, input logic [15:0] data,
                          input logic [15:0] lpc, input int n_instr, input string tag);
        applyStimulus(we, addr, data, 1'b1, lpc);
        pushItem(0, 0, 0, cyc + 2 * n_instr, {tag, "_exit_cycle"});
        pushItem(3, 0, 0, 0, {tag, "_busy_at_exit"});
        checkOutput({tag, "_busy_after_start"}, int'(busy), 1);
    endtask

    task automatic waitChecks(input int budget, input string tag);
        int base;
        int n;
        base = checks_done;
        n = 0;
        while (checks_done == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (checks_done == base) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: no exit within %0d cycles, expected exit", tag, budget);
            sb.delete();
        end
    endtask

    // Monitor: on each rising exit, pop and compare everything queued for that launch.
    initial begin : monitor
        logic seen;
        int   rise_cyc;
        int   act;
        exp_t it;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!exit) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                rise_cyc = cyc;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_exit: got exit=1 at cycle %0d, expected none", rise_cyc);
                end
                while (sb.size() != 0) begin
                    it = sb.pop_front();
                    case (it.kind)
                        0: act = rise_cyc;
                        1: act = int'(pc_out);
                        3: act = int'(busy);
                        default: begin
                            mon_active = 1'b1;
                            mon_lane   = 2'(it.lane);
                            mon_reg    = 3'(it.rsel);
                            #1;
                            act = int'(dbg_data);
                        end
                    endcase
                    checkOutput(it.name, act, it.expv);
                end
                mon_active = 1'b0;
                checks_done++;
            end
        end
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_pc_out", int'(pc_out), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_exit", int'(exit), 0);
        stim_lane = 2'd2; stim_reg = 3'd1;
        #1 checkOutput("reset_l2_r1", int'(dbg_data), 0);
        stim_lane = 2'd3; stim_reg = 3'd0;
        #1 checkOutput("reset_l3_r0", int'(dbg_data), 3);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: LDI r1,5; ADDI r2,r1,-1; ADD r3,r0,r2; EXIT, plus writes/starts while busy
        loadWord(16'h0000, 16'h4205);
        loadWord(16'h0001, 16'h347F);
        loadWord(16'h0002, 16'h1610);
        loadWord(16'h0003, 16'hF000);
        pushItem(1, 0, 0, 16'h0004, "t1_pc_out");
        for (int k = 0; k < 4; k++) pushReg(k, 3, 4 + k, "t1");
        pushReg(0, 2, 4, "t1");
        pushReg(3, 1, 5, "t1");
        launch(1'b0, 16'h0, 16'h0, 16'h0000, 4, "t1");
        applyStimulus(1'b1, 16'h0003, 16'h0000, 1'b1, 16'h0020);
        waitChecks(60, "t1");

        // T2: JMP 0x010 skips the LDI at 1; EXIT at 0x010; r1 keeps 5 across relaunch
        loadWord(16'h0000, 16'h5010);
        loadWord(16'h0001, 16'h4209);
        loadWord(16'h0010, 16'hF000);
        pushItem(1, 0, 0, 16'h0011, "t2_pc_out");
        for (int k = 0; k < 4; k++) pushReg(k, 1, 5, "t2");
        launch(1'b0, 16'h0, 16'h0, 16'h0000, 2, "t2");
        waitChecks(60, "t2");

        // T3: BNZ countdown loop, 8 instructions executed
        loadWord(16'h0000, 16'h4203);
        loadWord(16'h0001, 16'h327F);
        loadWord(16'h0002, 16'h607E);
        loadWord(16'h0003, 16'hF000);
        pushItem(1, 0, 0, 16'h0004, "t3_pc_out");
        for (int k = 0; k < 4; k++) pushReg(k, 1, 0, "t3");
        launch(1'b0, 16'h0, 16'h0, 16'h0000, 8, "t3");
        waitChecks(80, "t3");

        // T4: LDI r0,7 is discarded; SUB r6,r0,r5 wraps below zero
        loadWord(16'h0000, 16'h4007);
        loadWord(16'h0001, 16'h4A02);
        loadWord(16'h0002, 16'h2C28);
        loadWord(16'h0003, 16'hF000);
        pushItem(1, 0, 0, 16'h0004, "t4_pc_out");
        for (int k = 0; k < 4; k++) pushReg(k, 0, k, "t4");
        pushReg(0, 6, 16'hFFFE, "t4");
        pushReg(1, 6, 16'hFFFF, "t4");
        pushReg(2, 6, 16'h0000, "t4");
        pushReg(3, 6, 16'h0001, "t4");
        pushReg(1, 5, 2, "t4");
        launch(1'b0, 16'h0, 16'h0, 16'h0000, 4, "t4");
        waitChecks(60, "t4");

        // T5: PC wrap from 0xFFFF; EXIT written in the same cycle as start
        loadWord(16'h00FF, 16'h0000);
        pushItem(1, 0, 0, 16'h0000, "t5_pc_out");
        launch(1'b1, 16'h00FF, 16'hF000, 16'hFFFF, 1, "t5");
        waitChecks(40, "t5");

        // T6: reset dropped mid-loop aborts immediately and clears registers
        loadWord(16'h0000, 16'h4232);
        loadWord(16'h0001, 16'h327F);
        loadWord(16'h0002, 16'h607E);
        loadWord(16'h0003, 16'hF000);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 16'h0000);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("t6_busy_mid_loop", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_abort_busy", int'(busy), 0);
        checkOutput("t6_abort_exit", int'(exit), 0);
        checkOutput("t6_abort_pc_out", int'(pc_out), 0);
        stim_lane = 2'd0; stim_reg = 3'd1;
        #1 checkOutput("t6_abort_l0_r1", int'(dbg_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_idle_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
